// File: rtl/jbus_xfer.sv
// jbus_xfer: bus transfer initiator. Sequences one register-to-register move
// over the shared tristate bus using the stepper order: enable source, strobe
// destination set, drop set while enable holds, drop enable.
// Optional feature macro: JBUS_XFER_IMM_EN adds immediate-data transfers in
// which this block drives the bus itself instead of enabling a source register.

`ifndef ARCH_BITS
`define ARCH_BITS 8
`endif

module jbus_xfer #(
    parameter int NREG = 4,
    parameter int SELW = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req,
    input  logic [SELW-1:0]       src,
    input  logic [SELW-1:0]       dst,
`ifdef JBUS_XFER_IMM_EN
    input  logic                  imm_req,
    input  logic [`ARCH_BITS-1:0] imm_data,
`endif
    output logic                  busy,
    output logic                  ack,
    output logic                  err,
    output logic [NREG-1:0]       bus_en,
    output logic [NREG-1:0]       bus_set,
    inout  wire  [`ARCH_BITS-1:0] bus,
    output logic [`ARCH_BITS-1:0] xfer_data
);

    typedef enum logic [2:0] {IDLE, ENABLE, SET, HOLD, DONE} state_t;

    state_t          state, state_nxt;
    logic [SELW-1:0] src_q, dst_q;
    logic            err_q, imm_q;
    logic            src_ok, dst_ok;
    logic            start, start_imm, reject;
    logic            drive_phase;
    logic [NREG-1:0] src_dec, dst_dec;

    // Range check of the incoming indices against the registers actually present.
    always_comb begin
        src_ok = 1'b0;
        dst_ok = 1'b0;
        for (int i = 0; i < NREG; i++) begin
            if (int'(src) == i) src_ok = 1'b1;
            if (int'(dst) == i) dst_ok = 1'b1;
        end
    end

`ifdef JBUS_XFER_IMM_EN
    logic [`ARCH_BITS-1:0] imm_data_q;

    // Immediate requests win over register moves and only need a valid destination.
    assign start_imm = imm_req;
    assign start     = req | imm_req;
    assign reject    = imm_req ? !dst_ok : (!src_ok || !dst_ok || (src == dst));

    // Immediate value is frozen at accept so the bus stays stable for the whole move.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            imm_data_q <= '0;
        else if (state == IDLE && imm_req)
            imm_data_q <= imm_data;
    end

    // Bus is driven only while an immediate move is in its enable window.
    assign bus = (drive_phase && imm_q) ? imm_data_q : 'z;
`else
    assign start_imm = 1'b0;
    assign start     = req;
    assign reject    = !src_ok || !dst_ok || (src == dst);
`endif

    // State register; reset drops straight to IDLE so no strobe survives it.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    // Request capture in IDLE; later src/dst changes are ignored until DONE.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            src_q <= '0;
            dst_q <= '0;
            err_q <= 1'b0;
            imm_q <= 1'b0;
        end else if (state == IDLE && start) begin
            src_q <= src;
            dst_q <= dst;
            err_q <= reject;
            imm_q <= start_imm;
        end else if (state == DONE) begin
            err_q <= 1'b0;
        end
    end

    // One-hot decode of the latched indices.
    always_comb begin
        src_dec = '0;
        dst_dec = '0;
        for (int i = 0; i < NREG; i++) begin
            src_dec[i] = (int'(src_q) == i);
            dst_dec[i] = (int'(dst_q) == i);
        end
    end

    // Next state and state-decoded strobes; nothing here depends on live inputs
    // except the IDLE branch choice.
    always_comb begin
        state_nxt   = state;
        busy        = 1'b1;
        ack         = 1'b0;
        err         = 1'b0;
        bus_en      = '0;
        bus_set     = '0;
        drive_phase = 1'b0;
        case (state)
            IDLE: begin
                busy = 1'b0;
                if (start) state_nxt = reject ? DONE : ENABLE;
            end
            ENABLE: begin
                drive_phase = 1'b1;
                state_nxt   = SET;
            end
            SET: begin
                drive_phase = 1'b1;
                bus_set     = dst_dec;
                state_nxt   = HOLD;
            end
            HOLD: begin
                drive_phase = 1'b1;
                state_nxt   = DONE;
            end
            DONE: begin
                ack       = 1'b1;
                err       = err_q;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
        if (drive_phase && !imm_q) bus_en = src_dec;
    end

    // Snapshot of the bus on the edge leaving SET; held across rejects.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            xfer_data <= '0;
        else if (state == SET)
            xfer_data <= bus;
    end

endmodule

// File: tb/tb_jbus_xfer.sv
// Bench for jbus_xfer: a register-file responder model on the bus, a
// scoreboard of expected transfer results checked on each ack, and
// cycle-accurate strobe checks for each scenario.

`ifndef ARCH_BITS
`define ARCH_BITS 8
`endif

`timescale 1ns/1ps

module tb_jbus_xfer;
    localparam int W = `ARCH_BITS;

    typedef struct packed {
        logic         err;
        logic [1:0]   dst;
        logic [W-1:0] data;
    } exp_t;

    logic         clk, reset;
    logic         req, busy, ack, err;
    logic [1:0]   src, dst;
    logic [3:0]   bus_en, bus_set;
    wire  [W-1:0] bus;
    logic [W-1:0] xfer_data;

    logic         req3, busy3, ack3, err3;
    logic [1:0]   src3, dst3;
    logic [2:0]   en3, set3;
    wire  [W-1:0] bus3;
    logic [W-1:0] xd3;

`ifdef JBUS_XFER_IMM_EN
    logic         imm_req;
    logic [W-1:0] imm_data;
`endif

    int           n_vec = 0;
    int           n_bad = 0;
    int           n_ack = 0;
    int           exp_acks = 0;
    exp_t         sb[$];
    logic [W-1:0] mregs[4];
    logic [W-1:0] last_xd;
    logic [W-1:0] regs[4];
    logic [1:0]   en_idx;

    jbus_xfer #(.NREG(4), .SELW(2)) u_dut (
        .clk(clk), .reset(reset), .req(req), .src(src), .dst(dst),
`ifdef JBUS_XFER_IMM_EN
        .imm_req(imm_req), .imm_data(imm_data),
`endif
        .busy(busy), .ack(ack), .err(err), .bus_en(bus_en), .bus_set(bus_set),
        .bus(bus), .xfer_data(xfer_data)
    );

    jbus_xfer #(.NREG(3), .SELW(2)) u_dut3 (
        .clk(clk), .reset(reset), .req(req3), .src(src3), .dst(dst3),
`ifdef JBUS_XFER_IMM_EN
        .imm_req(1'b0), .imm_data('0),
`endif
        .busy(busy3), .ack(ack3), .err(err3), .bus_en(en3), .bus_set(set3),
        .bus(bus3), .xfer_data(xd3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Responder registers: enabled register drives the bus, set strobe captures it.
    always_comb begin
        en_idx = '0;
        for (int i = 0; i < 4; i++) if (bus_en[i]) en_idx = 2'(i);
    end
    assign bus  = (|bus_en) ? regs[en_idx] : 'z;
    assign bus3 = (|en3) ? 8'h5A : 'z;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            regs[0] <= 8'h11; regs[1] <= 8'hA5; regs[2] <= 8'h22; regs[3] <= 8'h33;
        end else begin
            for (int i = 0; i < 4; i++) if (bus_set[i]) regs[i] <= bus;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [3:0] oh(input logic [1:0] i);
        logic [3:0] one;
        one = 4'b0001;
        return one << i;
    endfunction

    task automatic model_reset();
        mregs[0] = 8'h11; mregs[1] = 8'hA5; mregs[2] = 8'h22; mregs[3] = 8'h33;
        last_xd  = '0;
    endtask

    // Predict the outcome of a register move from the model register file.
    task automatic push_xfer(input logic [1:0] s, input logic [1:0] d);
        exp_t e;
        e.dst = d;
        if (s == d) begin
            e.err  = 1'b1;
            e.data = last_xd;
        end else begin
            e.err    = 1'b0;
            e.data   = mregs[s];
            mregs[d] = mregs[s];
            last_xd  = mregs[s];
        end
        sb.push_back(e);
        exp_acks++;
    endtask

    task automatic cyc();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Full single transfer with per-cycle strobe checks.
    task automatic run_xfer(input logic [1:0] s, input logic [1:0] d);
        req = 1'b1; src = s; dst = d;
        push_xfer(s, d);
        cyc();
        req = 1'b0;
        if (s == d) begin
            chk("rej_ack", ack, 1);
            chk("rej_err", err, 1);
            chk("rej_en", bus_en, 0);
            chk("rej_set", bus_set, 0);
        end else begin
            for (int c = 1; c <= 4; c++) begin
                if (c > 1) cyc();
                chk($sformatf("x%0d%0d_en_c%0d", s, d, c), bus_en, (c <= 3) ? oh(s) : 4'b0);
                chk($sformatf("x%0d%0d_set_c%0d", s, d, c), bus_set, (c == 2) ? oh(d) : 4'b0);
                chk($sformatf("x%0d%0d_ack_c%0d", s, d, c), ack, (c == 4));
                chk($sformatf("x%0d%0d_busy_c%0d", s, d, c), busy, 1);
            end
        end
        cyc();
        chk("idle_busy", busy, 0);
    endtask

    // Scoreboard check on every ack, plus strobe invariants every cycle.
    always @(negedge clk) begin
        if (!reset) begin
            if (ack) begin
                n_ack++;
                if (sb.size() == 0) begin
                    chk("sb_unexpected_ack", 1, 0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("sb_err", err, e.err);
                    chk("sb_xfer_data", xfer_data, e.data);
                    if (!e.err) chk("sb_reg_dst", regs[e.dst], e.data);
                end
            end
            if (bus_set != 0) begin
                chk("inv_set_onehot", $countones(bus_set), 1);
                chk("inv_set_needs_en", (bus_en != 0), 1);
            end
            if (bus_en != 0) chk("inv_en_onehot", $countones(bus_en), 1);
        end
    end

    initial begin
        int ack0;
        reset = 1'b1; req = 1'b0; src = '0; dst = '0;
        req3 = 1'b0; src3 = '0; dst3 = '0;
`ifdef JBUS_XFER_IMM_EN
        imm_req = 1'b0; imm_data = '0;
`endif
        model_reset();
        #3;
        chk("rst_busy", busy, 0);
        chk("rst_ack", ack, 0);
        chk("rst_err", err, 0);
        chk("rst_en", bus_en, 0);
        chk("rst_set", bus_set, 0);
        chk("rst_xfer_data", xfer_data, 0);
        @(negedge clk);
        reset = 1'b0;
        cyc();

        // Valid move and a same-register reject.
        run_xfer(2'd1, 2'd3);
        run_xfer(2'd2, 2'd2);

        // Out-of-range indices on a three-register bus.
        for (int k = 0; k < 2; k++) begin
            req3 = 1'b1;
            src3 = (k == 0) ? 2'd0 : 2'd3;
            dst3 = (k == 0) ? 2'd3 : 2'd0;
            cyc();
            req3 = 1'b0;
            chk("n3_ack", ack3, 1);
            chk("n3_err", err3, 1);
            chk("n3_en", en3, 0);
            chk("n3_set", set3, 0);
            chk("n3_busy", busy3, 1);
            chk("n3_xd", xd3, 0);
            cyc();
        end

        // Back-to-back with req held; indices change while busy.
        req = 1'b1; src = 2'd0; dst = 2'd1;
        push_xfer(2'd0, 2'd1);
        for (int c = 1; c <= 9; c++) begin
            cyc();
            if (c == 1) begin
                src = 2'd1; dst = 2'd2;
                push_xfer(2'd1, 2'd2);
            end
            chk($sformatf("b2b_ack_c%0d", c), ack, (c == 4 || c == 9));
            if (c >= 6 && c <= 8) chk($sformatf("b2b_en_c%0d", c), bus_en, 4'b0010);
            if (c == 7) chk("b2b_set_c7", bus_set, 4'b0100);
            if (c == 9) req = 1'b0;
        end
        cyc();
        chk("b2b_idle", busy, 0);

        // A request pulse during SET must be ignored.
        ack0 = n_ack;
        req = 1'b1; src = 2'd3; dst = 2'd0;
        push_xfer(2'd3, 2'd0);
        for (int c = 1; c <= 7; c++) begin
            cyc();
            req = (c == 2);
            if (c == 2) begin src = 2'd0; dst = 2'd1; end
            if (c == 3) chk("ign_en_latched", bus_en, 4'b1000);
        end
        chk("ign_one_ack", n_ack - ack0, 1);
        chk("ign_idle", busy, 0);

        // Reset asserted during SET aborts at once.
        req = 1'b1; src = 2'd1; dst = 2'd2;
        cyc();
        req = 1'b0;
        cyc();
        chk("ab_set_pre", bus_set, 4'b0100);
        #2 reset = 1'b1;
        #1;
        chk("ab_set", bus_set, 0);
        chk("ab_en", bus_en, 0);
        chk("ab_busy", busy, 0);
        chk("ab_xd", xfer_data, 0);
        model_reset();
        @(negedge clk);
        reset = 1'b0;
        cyc();
        run_xfer(2'd1, 2'd0);

`ifdef JBUS_XFER_IMM_EN
        // Immediate move takes priority over a simultaneous register move.
        begin
            exp_t e;
            imm_req = 1'b1; imm_data = 8'h3C; dst = 2'd0;
            req = 1'b1; src = 2'd2;
            e.err = 1'b0; e.dst = 2'd0; e.data = 8'h3C;
            sb.push_back(e);
            exp_acks++;
            mregs[0] = 8'h3C; last_xd = 8'h3C;
            for (int c = 1; c <= 4; c++) begin
                cyc();
                imm_req = 1'b0; req = 1'b0; imm_data = 8'hFF;
                if (c <= 3) chk($sformatf("imm_bus_c%0d", c), bus, 8'h3C);
                chk($sformatf("imm_en_c%0d", c), bus_en, 0);
                chk($sformatf("imm_set_c%0d", c), bus_set, (c == 2) ? 4'b0001 : 4'b0);
                chk($sformatf("imm_ack_c%0d", c), ack, (c == 4));
            end
            cyc();
        end
`endif

        cyc();
        chk("sb_drained", sb.size(), 0);
        chk("ack_count", n_ack, exp_acks);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/jbus_xfer.md
Name: jbus_xfer

Overview:
- Bus transfer initiator: the control-side counterpart of the register/enabler bus interface.
- On request, drives one-hot enable and set strobes to move one register's value to another over the shared tristate bus. Registers are the responders; this block sequences them.
- Uses the stepper convention: enable first, then set, then release set while enable is held, then release enable.

Parameters:
- NREG, 4, number of registers on the bus (one enable line and one set line each).
- SELW, 2, width of the src/dst register index; NREG <= 2**SELW.
- Data width is `ARCH_BITS from the shared defs file; it is not a parameter.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- req  input  1  transfer request; sampled only in IDLE.
- src  input  SELW  source register index; sampled with req.
- dst  input  SELW  destination register index; sampled with req.
- busy  output  1  high in every state except IDLE.
- ack  output  1  one-cycle pulse when a transfer completes or is rejected.
- err  output  1  one-cycle pulse coincident with ack on a rejected request.
- bus_en  output  NREG  one-hot register enable (register we inputs).
- bus_set  output  NREG  one-hot register set strobe (register ws inputs).
- bus  inout  `ARCH_BITS  shared data bus. Input only unless the optional feature is driving it.
- xfer_data  output  `ARCH_BITS  bus value captured during the SET state.

Behaviour:
- Reset:
  - Asynchronous, active-high; no clk edge needed to take effect.
  - State=IDLE; busy, ack, err = 0; bus_en = 0; bus_set = 0; xfer_data = 0; bus released (z).
  - Reset mid-transfer aborts immediately. No set pulse may appear after reset rises. Any partial register update is not this block's concern.
- States: IDLE, ENABLE, SET, HOLD, DONE.
- IDLE:
  - If req=1 at the clk edge, latch src_q and dst_q.
  - If src_q or dst_q >= NREG, or src_q == dst_q: go to DONE with err_q=1.
  - Otherwise go to ENABLE.
  - req=0: stay in IDLE.
- ENABLE (1 cycle): bus_en[src_q]=1; go to SET.
- SET (1 cycle):
  - bus_en[src_q]=1 and bus_set[dst_q]=1.
  - xfer_data loads bus at the clk edge leaving SET.
  - Go to HOLD.
- HOLD (1 cycle): bus_en[src_q]=1, bus_set=0; go to DONE.
- DONE (1 cycle):
  - bus_en=0; ack=1; err=err_q.
  - Go to IDLE and clear err_q.
- Output timing:
  - All outputs are registered or decoded from state only. No combinational path from req, src or dst to any output.
  - At most one bit of bus_en and at most one bit of bus_set is high in any cycle.
  - bus_set is never high unless bus_en is high.
- Latency:
  - Valid request accepted at edge t: ENABLE in cycle t+1, SET t+2, HOLD t+3, ack at t+4.
  - Rejected request: ack and err in cycle t+1, with bus_en and bus_set 0 throughout.
- req held high continuously: a new transfer starts on the IDLE edge after DONE. Back-to-back throughput is one transfer per 5 cycles.
- req while busy=1: ignored, not queued.
- src/dst changing while busy: no effect, because the latched copies are used.
- xfer_data holds its value until the next SET, including across rejected requests.

Optional Feature:
- Macro: JBUS_XFER_IMM_EN.
- When defined:
  - Adds input imm_req (1 bit) and input imm_data (`ARCH_BITS).
  - imm_req=1 in IDLE starts an immediate transfer; imm_req takes priority over req when both are high.
  - For an immediate transfer, no bus_en bit is asserted. Instead this block drives bus=imm_data_q (latched at accept) during ENABLE, SET and HOLD.
  - Same sequence and latency as a normal transfer. Only dst is checked (dst >= NREG → err).
  - The bus is z in all other states.
- When undefined: the ports do not exist, and the bus is never driven by this block.

Test Plan:
- Reset: assert reset mid-SET (bus_set[2]=1) → bus_set=0, bus_en=0 and busy=0 immediately, before the next clk edge; xfer_data=0.
- Valid transfer: register 1 holds 8'hA5; req with src=1, dst=3 at edge 0 → bus_en=4'b0010 in cycles 1-3, bus_set=4'b1000 in cycle 2 only, ack=1 in cycle 4, xfer_data=8'hA5, register 3 reads 8'hA5.
- Rejects: req with src=2, dst=2 → ack=1 and err=1 at cycle 1, bus_en and bus_set stay 0. Repeat with NREG=3, dst=3 → same result.
- Back-to-back: req held high with (0→1), then src/dst changed to (1→2) during busy → first ack at cycle 4, second transfer ENABLE at cycle 6 using (1→2), second ack at cycle 9.
- Ignore while busy: pulse req with src=0, dst=1 during the SET of an ongoing transfer → no extra transfer, exactly one ack.
- Immediate (JBUS_XFER_IMM_EN): imm_req with imm_data=8'h3C, dst=0 → bus=8'h3C in cycles 1-3, bus_en=0 throughout, bus_set=4'b0001 in cycle 2, register 0 = 8'h3C, bus z at cycle 4.
